// File: rtl/fp16_accumulator_if.sv
// Stream port bundle for fp16_accumulator: operand input handshake and result output handshake.
// The slave modport is the accumulator side; master is the producer/consumer side.
interface fp16_accumulator_if #(
   parameter int CNT_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_sum;
   logic [CNT_W-1:0] out_count;
   logic             out_trunc;
   logic             out_ovf;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_count, out_trunc, out_ovf
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_count, out_trunc, out_ovf
   );
endinterface

// File: rtl/fp16_accumulator.sv
// Streaming fp16 packet accumulator built around the combinational floatAdd adder.
// Optional sticky exponent-wrap flag is enabled by defining FP16_ACC_OVF_DETECT_EN.

// Truncating fp16 adder: no rounding, no NaN/Inf, zero exponent results flush to zero.
module floatAdd (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] sum
);
   logic        swap;
   logic [15:0] hi;
   logic [15:0] lo;
   logic [10:0] hi_m;
   logic [10:0] lo_m;
   logic [11:0] sum12;
   logic [10:0] diff11;
   logic [5:0]  e6;
   logic [3:0]  lz;
   logic        found;
   logic [9:0]  norm;

   assign swap   = b[14:0] > a[14:0];
   assign hi     = swap ? b : a;
   assign lo     = swap ? a : b;
   assign hi_m   = {1'b1, hi[9:0]};
   assign lo_m   = {1'b1, lo[9:0]} >> (hi[14:10] - lo[14:10]);
   assign sum12  = {1'b0, hi_m} + {1'b0, lo_m};
   assign diff11 = hi_m - lo_m;
   assign e6     = {1'b0, hi[14:10]} + 6'd1;
   assign norm   = 10'(diff11 << lz);

   // Leading-zero count for renormalising the difference path
   always_comb begin
      lz    = 4'd0;
      found = 1'b0;
      for (int i = 10; i >= 0; i--) begin
         if (!found) begin
            if (diff11[i]) found = 1'b1;
            else           lz    = lz + 4'd1;
         end
      end
   end

   always_comb begin
      sum = 16'h0000;
      if (a[14:0] == 15'd0) begin
         sum = b;
      end else if (b[14:0] == 15'd0) begin
         sum = a;
      end else if (hi[15] == lo[15]) begin
         if (!sum12[11])  sum = {hi[15], hi[14:10], sum12[9:0]};
         else if (!e6[5]) sum = {hi[15], e6[4:0], sum12[10:1]};
         else             sum = 16'h0000;
      end else if (diff11 != 11'd0 && {1'b0, hi[14:10]} > {2'b00, lz}) begin
         sum = {hi[15], hi[14:10] - {1'b0, lz}, norm};
      end
   end
endmodule

module fp16_accumulator #(
   parameter int MAX_BEATS = 16,
   parameter int CNT_W     = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   fp16_accumulator_if.slave   bus
);
   typedef enum logic {ACC, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic [15:0]      acc;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_inc;
   logic [15:0]      add_sum;
   logic [15:0]      out_sum_r;
   logic [CNT_W-1:0] out_count_r;
   logic             out_trunc_r;
   logic             accept;
   logic             close;
   logic             handshake;

   floatAdd u_add (
      .a   (acc),
      .b   (bus.in_data),
      .sum (add_sum)
   );

   assign bus.in_ready  = (state == ACC) && !clear;
   assign bus.out_valid = (state == DONE);
   assign bus.out_sum   = out_sum_r;
   assign bus.out_count = out_count_r;
   assign bus.out_trunc = out_trunc_r;

   assign accept    = bus.in_valid && bus.in_ready;
   assign count_inc = count + 1'b1;
   assign close     = bus.in_last || (count_inc == CNT_W'(MAX_BEATS));
   assign handshake = (state == DONE) && bus.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ACC;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (clear) begin
         state_next = ACC;
      end else begin
         case (state)
            ACC:     if (accept && close) state_next = DONE;
            DONE:    if (bus.out_ready)   state_next = ACC;
            default: state_next = ACC;
         endcase
      end
   end

   // Result registers load on the closing beat and stay frozen until the handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc         <= 16'h0000;
         count       <= '0;
         out_sum_r   <= 16'h0000;
         out_count_r <= '0;
         out_trunc_r <= 1'b0;
      end else if (clear || handshake) begin
         acc   <= 16'h0000;
         count <= '0;
      end else if (accept) begin
         acc   <= add_sum;
         count <= count_inc;
         if (close) begin
            out_sum_r   <= add_sum;
            out_count_r <= count_inc;
            out_trunc_r <= !bus.in_last;
         end
      end
   end

`ifdef FP16_ACC_OVF_DETECT_EN
   logic ovf;
   logic ovf_det;
   logic out_ovf_r;

   // A same-sign add of two nonzero values can only yield zero through exponent wrap
   assign ovf_det = (acc != 16'h0000) && (bus.in_data != 16'h0000) &&
                    (acc[15] == bus.in_data[15]) && (add_sum == 16'h0000);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf       <= 1'b0;
         out_ovf_r <= 1'b0;
      end else if (clear || handshake) begin
         ovf       <= 1'b0;
         out_ovf_r <= 1'b0;
      end else if (accept) begin
         ovf <= ovf | ovf_det;
         if (close) out_ovf_r <= ovf | ovf_det;
      end
   end

   assign bus.out_ovf = out_ovf_r;
`else
   assign bus.out_ovf = 1'b0;
`endif
endmodule
